// File: rtl/seg_frame_pkg.sv
// rtl/seg_frame_pkg.sv - segmented-frame geometry constants and writer state encoding
package seg_frame_pkg;

    localparam int NUM_STRIPS  = 8;
    localparam int STRIP_DEPTH = 6216;
    localparam int LAST_DEPTH  = 5772;
    localparam int ADDR_W      = 13;
    localparam int FRAME_BYTES = (NUM_STRIPS - 1) * STRIP_DEPTH + LAST_DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/strip_addr_gen.sv
// rtl/strip_addr_gen.sv - strip/address walker over a segmented frame with terminal flags
module strip_addr_gen
    import seg_frame_pkg::*;
#(
    parameter int NUM_STRIPS  = seg_frame_pkg::NUM_STRIPS,
    parameter int STRIP_DEPTH = seg_frame_pkg::STRIP_DEPTH,
    parameter int LAST_DEPTH  = seg_frame_pkg::LAST_DEPTH,
    parameter int ADDR_W      = seg_frame_pkg::ADDR_W,
    localparam int STRIP_W    = $clog2(NUM_STRIPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    output logic [STRIP_W-1:0] strip,
    output logic [ADDR_W-1:0]  addr,
    output logic               wrap,
    output logic               last_strip
);

    logic [ADDR_W-1:0] depth_m1;

    // Terminal flags: the last strip is shorter, so the wrap point depends on strip
    always_comb begin
        last_strip = (strip == STRIP_W'(NUM_STRIPS - 1));
        depth_m1   = last_strip ? ADDR_W'(LAST_DEPTH - 1) : ADDR_W'(STRIP_DEPTH - 1);
        wrap       = (addr == depth_m1);
    end

    // Position register: clear wins over advance; wrapping moves to the next strip
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strip <= '0;
            addr  <= '0;
        end else if (clear) begin
            strip <= '0;
            addr  <= '0;
        end else if (advance) begin
            if (wrap) begin
                addr  <= '0;
                strip <= last_strip ? '0 : strip + STRIP_W'(1);
            end else begin
                addr  <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_bram_writer.sv
// rtl/uart_bram_writer.sv - writes a received UART byte stream into the strip BRAMs of a segmented frame
module uart_bram_writer
    import seg_frame_pkg::*;
#(
    parameter int NUM_STRIPS  = seg_frame_pkg::NUM_STRIPS,
    parameter int STRIP_DEPTH = seg_frame_pkg::STRIP_DEPTH,
    parameter int LAST_DEPTH  = seg_frame_pkg::LAST_DEPTH,
    parameter int ADDR_W      = seg_frame_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic [NUM_STRIPS-1:0] bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [7:0]            bram_din,
    output logic [NUM_STRIPS-1:0] strip_done,
    output logic                  frame_done,
    output logic                  overrun,
    output logic [15:0]           byte_count
);

    localparam int STRIP_W = $clog2(NUM_STRIPS);

    state_t               state_q, state_d;
    logic [STRIP_W-1:0]   strip;
    logic [ADDR_W-1:0]    addr;
    logic                 wrap, last_strip;
    logic                 accept, late_byte;

    strip_addr_gen #(
        .NUM_STRIPS (NUM_STRIPS),
        .STRIP_DEPTH(STRIP_DEPTH),
        .LAST_DEPTH (LAST_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .advance   (accept),
        .strip     (strip),
        .addr      (addr),
        .wrap      (wrap),
        .last_strip(last_strip)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: start re-arms from anywhere; the final byte of strip 7 ends the frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RECV;
            ST_RECV: begin
                if (start)                              state_d = ST_RECV;
                else if (accept && wrap && last_strip)  state_d = ST_DONE;
            end
            ST_DONE: if (start) state_d = ST_RECV;
            default: state_d = ST_IDLE;
        endcase
    end

    // Decode: a byte coinciding with start is dropped; bytes after the frame flag overrun
    always_comb begin
        accept    = (state_q == ST_RECV) && rx_valid && !start;
        late_byte = (state_q == ST_DONE) && rx_valid && !start;
    end

    // Write port: one-cycle enable, address/data hold between writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bram_we   <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else if (accept) begin
            bram_we   <= NUM_STRIPS'(1) << strip;
            bram_addr <= addr;
            bram_din  <= rx_data;
        end else begin
            bram_we   <= '0;
        end
    end

    // Progress and status flags, rising together with the write that completes them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strip_done <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            byte_count <= '0;
        end else if (start) begin
            strip_done <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            byte_count <= '0;
        end else begin
            if (accept) begin
                byte_count <= byte_count + 16'd1;
                if (wrap) begin
                    strip_done[strip] <= 1'b1;
                    if (last_strip) frame_done <= 1'b1;
                end
            end
            if (late_byte) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_bram_writer.sv
// tb/tb_uart_bram_writer.sv - directed self-checking bench for uart_bram_writer
module tb_uart_bram_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  bram_we;
    logic [12:0] bram_addr;
    logic [7:0]  bram_din;
    logic [7:0]  strip_done;
    logic        frame_done;
    logic        overrun;
    logic [15:0] byte_count;

    int errors = 0;
    int checks = 0;

    uart_bram_writer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .strip_done(strip_done),
        .frame_done(frame_done),
        .overrun   (overrun),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    function automatic void exp_loc(input int idx, output int s, output int a);
        if (idx < 7 * 6216) begin
            s = idx / 6216;
            a = idx % 6216;
        end else begin
            s = 7;
            a = idx - 7 * 6216;
        end
    endfunction

    function automatic logic [7:0] exp_done(input int s, input int a);
        int depth = (s == 7) ? 5772 : 6216;
        int completed = s + ((a == depth - 1) ? 1 : 0);
        int m = (1 << completed) - 1;
        return m[7:0];
    endfunction

    task automatic tick_byte(input logic [7:0] d);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic with_byte);
        @(negedge clk);
        start    = 1'b1;
        rx_valid = with_byte;
        rx_data  = 8'hAA;
        @(posedge clk);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bram_we, bram_addr, bram_din, strip_done, frame_done, overrun, byte_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%h addr=%0d din=%h sd=%h fd=%b ov=%b bc=%0d, expected all 0",
                     bram_we, bram_addr, bram_din, strip_done, frame_done, overrun, byte_count);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_pre_start();
        int bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick_byte(8'h30 + 8'(i));
            if (bram_we !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pre_start_no_write: got %0d writes, expected 0", bad);
        end
        checks++;
        if (overrun !== 1'b0 || byte_count !== 16'd0) begin
            errors++;
            $display("FAIL pre_start_flags: got ov=%b bc=%0d, expected ov=0 bc=0", overrun, byte_count);
        end
    endtask

    task automatic test_full_frame();
        int bad_strip [8];
        int bad_flags = 0;
        int s, a;
        for (int i = 0; i < 8; i++) bad_strip[i] = 0;
        pulse_start(1'b0);
        checks++;
        if (bram_we !== 8'h00 || byte_count !== 16'd0) begin
            errors++;
            $display("FAIL start_no_write: got we=%h bc=%0d, expected we=00 bc=0", bram_we, byte_count);
        end
        for (int idx = 0; idx < 49284; idx++) begin
            tick_byte(idx[7:0]);
            exp_loc(idx, s, a);
            if (bram_we !== 8'(1 << s) || bram_addr !== 13'(a) || bram_din !== idx[7:0])
                bad_strip[s]++;
            if (strip_done !== exp_done(s, a) || frame_done !== (idx == 49283) ||
                byte_count !== 16'(idx + 1) || overrun !== 1'b0)
                bad_flags++;
            if (idx == 6215) begin
                checks++;
                if (bram_we !== 8'h01 || bram_addr !== 13'd6215 || strip_done !== 8'h01) begin
                    errors++;
                    $display("FAIL strip0_last: got we=%h addr=%0d sd=%h, expected we=01 addr=6215 sd=01",
                             bram_we, bram_addr, strip_done);
                end
            end
            if (idx == 6216) begin
                checks++;
                if (bram_we !== 8'h02 || bram_addr !== 13'd0 || bram_din !== 8'h48) begin
                    errors++;
                    $display("FAIL strip1_first: got we=%h addr=%0d din=%h, expected we=02 addr=0 din=48",
                             bram_we, bram_addr, bram_din);
                end
            end
            if (idx == 49283) begin
                checks++;
                if (bram_we !== 8'h80 || bram_addr !== 13'd5771 || frame_done !== 1'b1 ||
                    strip_done !== 8'hFF) begin
                    errors++;
                    $display("FAIL strip7_last: got we=%h addr=%0d fd=%b sd=%h, expected we=80 addr=5771 fd=1 sd=FF",
                             bram_we, bram_addr, frame_done, strip_done);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bad_strip[i] != 0) begin
                errors++;
                $display("FAIL strip_content_%0d: got %0d bad writes, expected 0", i, bad_strip[i]);
            end
        end
        checks++;
        if (bad_flags != 0) begin
            errors++;
            $display("FAIL frame_flags_track: got %0d bad cycles, expected 0", bad_flags);
        end
        idle_cycle();
        checks++;
        if (bram_we !== 8'h00 || bram_addr !== 13'd5771 || bram_din !== 8'h83) begin
            errors++;
            $display("FAIL frame_hold: got we=%h addr=%0d din=%h, expected we=00 addr=5771 din=83",
                     bram_we, bram_addr, bram_din);
        end
        checks++;
        if (frame_done !== 1'b1 || byte_count !== 16'd49284 || overrun !== 1'b0 || strip_done !== 8'hFF) begin
            errors++;
            $display("FAIL frame_final: got fd=%b bc=%0d ov=%b sd=%h, expected fd=1 bc=49284 ov=0 sd=FF",
                     frame_done, byte_count, overrun, strip_done);
        end
    endtask

    task automatic test_post_done();
        int bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick_byte(8'hE0 + 8'(i));
            if (bram_we !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_done_no_write: got %0d writes, expected 0", bad);
        end
        checks++;
        if (overrun !== 1'b1 || byte_count !== 16'd49284 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL post_done_flags: got ov=%b bc=%0d fd=%b, expected ov=1 bc=49284 fd=1",
                     overrun, byte_count, frame_done);
        end
    endtask

    task automatic test_abort();
        pulse_start(1'b0);
        checks++;
        if (overrun !== 1'b0 || frame_done !== 1'b0 || strip_done !== 8'h00 || byte_count !== 16'd0) begin
            errors++;
            $display("FAIL rearm_clear: got ov=%b fd=%b sd=%h bc=%0d, expected all 0",
                     overrun, frame_done, strip_done, byte_count);
        end
        for (int i = 0; i < 3; i++) begin
            tick_byte(8'h10 + 8'(i));
            checks++;
            if (bram_we !== 8'h01 || bram_addr !== 13'(i) || bram_din !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL slow_write_%0d: got we=%h addr=%0d din=%h, expected we=01 addr=%0d din=%h",
                         i, bram_we, bram_addr, bram_din, i, 8'h10 + 8'(i));
            end
            repeat (3) idle_cycle();
            checks++;
            if (bram_we !== 8'h00 || bram_addr !== 13'(i) || bram_din !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL slow_hold_%0d: got we=%h addr=%0d din=%h, expected we=00 addr=%0d din=%h",
                         i, bram_we, bram_addr, bram_din, i, 8'h10 + 8'(i));
            end
        end
        for (int i = 3; i < 10000; i++) tick_byte(8'h5A);
        checks++;
        if (byte_count !== 16'd10000 || strip_done !== 8'h01) begin
            errors++;
            $display("FAIL pre_abort: got bc=%0d sd=%h, expected bc=10000 sd=01", byte_count, strip_done);
        end
        pulse_start(1'b1);
        checks++;
        if (bram_we !== 8'h00 || byte_count !== 16'd0 || strip_done !== 8'h00) begin
            errors++;
            $display("FAIL abort_same_cycle: got we=%h bc=%0d sd=%h, expected we=00 bc=0 sd=00",
                     bram_we, byte_count, strip_done);
        end
        tick_byte(8'h5C);
        checks++;
        if (bram_we !== 8'h01 || bram_addr !== 13'd0 || bram_din !== 8'h5C || byte_count !== 16'd1) begin
            errors++;
            $display("FAIL abort_first: got we=%h addr=%0d din=%h bc=%0d, expected we=01 addr=0 din=5C bc=1",
                     bram_we, bram_addr, bram_din, byte_count);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        pulse_start(1'b0);
        for (int i = 0; i < 3 * 6216 + 100; i++) tick_byte(8'h21);
        checks++;
        if (bram_we !== 8'h08 || bram_addr !== 13'd99 || strip_done !== 8'h07) begin
            errors++;
            $display("FAIL strip3_mid: got we=%h addr=%0d sd=%h, expected we=08 addr=99 sd=07",
                     bram_we, bram_addr, strip_done);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({bram_we, bram_addr, bram_din, strip_done, frame_done, overrun, byte_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: got we=%h addr=%0d din=%h sd=%h fd=%b ov=%b bc=%0d, expected all 0",
                     bram_we, bram_addr, bram_din, strip_done, frame_done, overrun, byte_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_byte(8'h44);
            if (bram_we !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0 || byte_count !== 16'd0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: got writes=%0d bc=%0d ov=%b, expected writes=0 bc=0 ov=0",
                     bad, byte_count, overrun);
        end
        pulse_start(1'b0);
        tick_byte(8'h77);
        checks++;
        if (bram_we !== 8'h01 || bram_addr !== 13'd0 || bram_din !== 8'h77) begin
            errors++;
            $display("FAIL after_reset_start: got we=%h addr=%0d din=%h, expected we=01 addr=0 din=77",
                     bram_we, bram_addr, bram_din);
        end
    endtask

    initial begin
        test_reset();
        test_pre_start();
        test_full_frame();
        test_post_done();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
